register_if_id_queue: RTL and testbench

REGISTER_IF_ID_QUEUE -- requirements
Module: register_if_id_queue

---
 rtl/register_if_id_queue_pkg.sv | 16 +
 rtl/register_if_id_queue_fifo_2entry.sv | 84 ++++++++
 rtl/register_if_id_queue.sv | 77 +++++++
 tb/tb_register_if_id_queue.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/register_if_id_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_if_id_queue_pkg
// Description : Shared pipeline constants for the fetch/decode boundary.
// Revision    : 1.0 - initial release
// ============================================================================
package register_if_id_queue_pkg;

    // Canonical RV32I NOP (addi x0, x0, 0) shown to decode when no entry is valid
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Entry count of the IF/ID fetch queue; pointers are one bit wide
    localparam int IFQ_DEPTH = 2;

endpackage : register_if_id_queue_pkg
`default_nettype wire

// File: rtl/register_if_id_queue_fifo_2entry.sv
`default_nettype none
// ============================================================================
// Module      : register_if_id_queue_fifo_2entry
// Description : Two-entry FIFO storage with 1-bit wrapping pointers and an
//               occupancy count. A clear empties the queue and drops any
//               concurrent push.
// Revision    : 1.0 - initial release
// ============================================================================
module register_if_id_queue_fifo_2entry #(
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [0:1];
    logic [WIDTH-1:0] mem_d [0:1];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             w_push;
    logic             w_pop;

    // Guard against overflow/underflow even if the wrapper misbehaves
    assign w_push = push & (count_q != 2'd2);
    assign w_pop  = pop  & (count_q != 2'd0);

    // Next-state: clear wins, otherwise write at tail and advance head
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            mem_d[0] = '0;
            mem_d[1] = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule : register_if_id_queue_fifo_2entry
`default_nettype wire

// File: rtl/register_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : register_if_id_queue
// Description : IF/ID pipeline register built as a two-entry fetch queue.
//               Decode stalls hold the head; an EX redirect flushes all
//               entries. Head outputs are register-derived only.
// Revision    : 1.0 - initial release
// ============================================================================
module register_if_id_queue
    import register_if_id_queue_pkg::*;
#(
    parameter int          N     = 32,
    parameter int          DEPTH = IFQ_DEPTH,
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] pc,
    input  logic [N-1:0] pc4,
    input  logic [N-1:0] instr,
    input  logic         stall,
    input  logic         flush,
    output logic         out_valid,
    output logic [N-1:0] pc_o,
    output logic [N-1:0] pc4_o,
    output logic [N-1:0] instr_o,
    output logic [1:0]   count_o
);

    localparam logic [1:0] C_DEPTH = 2'(DEPTH);
    localparam int         C_W     = 3 * N;

    logic [1:0]     w_count;
    logic [C_W-1:0] w_head;
    logic           w_push;
    logic           w_pop;
    logic           w_valid;

    // Full queue refuses the fetch word even if decode pops this cycle;
    // this keeps in_ready off any path through stall
    assign in_ready  = (w_count < C_DEPTH) & ~flush;
    assign w_valid   = (w_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = w_valid & ~stall & ~flush;

    register_if_id_queue_fifo_2entry #(
        .WIDTH (C_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({pc, pc4, instr}),
        .rdata (w_head),
        .count (w_count)
    );

    // Head presentation: empty queue shows zero addresses and a NOP
    always_comb begin
        out_valid = w_valid;
        pc_o      = '0;
        pc4_o     = '0;
        instr_o   = N'(NOP);
        if (w_valid) begin
            pc_o    = w_head[3*N-1:2*N];
            pc4_o   = w_head[2*N-1:N];
            instr_o = w_head[N-1:0];
        end
    end

    assign count_o = w_count;

endmodule : register_if_id_queue
`default_nettype wire

// File: tb/tb_register_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_if_id_queue
// Description : Directed self-checking bench for the IF/ID fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_if_id_queue;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic        in_ready, out_valid;
    logic [31:0] pc, pc4, instr, pc_o, pc4_o, instr_o;
    logic [1:0]  count_o;

    int errors = 0;
    int checks = 0;

    register_if_id_queue dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc        (pc),
        .pc4       (pc4),
        .instr     (instr),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .pc_o      (pc_o),
        .pc4_o     (pc4_o),
        .instr_o   (instr_o),
        .count_o   (count_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] w);
        in_valid = v;
        pc       = a;
        pc4      = a + 32'd4;
        instr    = w;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (instr_o !== C_NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instr_o, C_NOP); end
        checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (pc_o !== 32'h0 || pc4_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h/%h exp=0/0", pc_o, pc4_o); end
    endtask

    task automatic test_push();
        drive(1'b1, 32'h0, 32'h0050_0093);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL push_valid got=%b exp=1", out_valid); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL push_pc got=%h exp=0", pc_o); end
        checks++; if (pc4_o !== 32'h4) begin errors++; $display("FAIL push_pc4 got=%h exp=4", pc4_o); end
        checks++; if (instr_o !== 32'h0050_0093) begin errors++; $display("FAIL push_instr got=%h exp=00500093", instr_o); end
        checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL push_count got=%0d exp=1", count_o); end
        step();
        checks++; if (out_valid !== 1'b0 || count_o !== 2'd0 || instr_o !== C_NOP) begin errors++; $display("FAIL push_drain got=%b/%0d/%h exp=0/0/%h", out_valid, count_o, instr_o, C_NOP); end
    endtask

    task automatic test_stall_order();
        stall = 1'b1;
        drive(1'b1, 32'h4, 32'hAAAA_0001);
        step();
        drive(1'b1, 32'h8, 32'hBBBB_0002);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL stall_count got=%0d exp=2", count_o); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
        step();
        checks++; if (pc_o !== 32'h4 || instr_o !== 32'hAAAA_0001) begin errors++; $display("FAIL stall_hold got=%h/%h exp=4/aaaa0001", pc_o, instr_o); end
        stall = 1'b0;
        step();
        checks++; if (pc_o !== 32'h8 || pc4_o !== 32'hC || instr_o !== 32'hBBBB_0002 || count_o !== 2'd1) begin errors++; $display("FAIL stall_order got=%h/%h/%h/%0d exp=8/c/bbbb0002/1", pc_o, pc4_o, instr_o, count_o); end
        step();
        checks++; if (count_o !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%0d/%b exp=0/0", count_o, out_valid); end
    endtask

    task automatic test_full_pop();
        stall = 1'b1;
        drive(1'b1, 32'h10, 32'h1111_0010);
        step();
        drive(1'b1, 32'h14, 32'h1111_0014);
        step();
        stall = 1'b0;
        drive(1'b1, 32'h18, 32'h1111_0018);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_ready got=%b exp=0", in_ready); end
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (count_o !== 2'd1 || pc_o !== 32'h14 || instr_o !== 32'h1111_0014) begin errors++; $display("FAIL fullpop_head got=%0d/%h/%h exp=1/14/11110014", count_o, pc_o, instr_o); end
        step();
        checks++; if (count_o !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_nodup got=%0d/%b exp=0/0", count_o, out_valid); end
    endtask

    task automatic test_push_pop_one();
        drive(1'b1, 32'h40, 32'h2222_0040);
        step();
        drive(1'b1, 32'h44, 32'h2222_0044);
        checks++; if (pc_o !== 32'h40 || count_o !== 2'd1) begin errors++; $display("FAIL pp_first got=%h/%0d exp=40/1", pc_o, count_o); end
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (pc_o !== 32'h44 || instr_o !== 32'h2222_0044 || count_o !== 2'd1) begin errors++; $display("FAIL pp_swap got=%h/%h/%0d exp=44/22220044/1", pc_o, instr_o, count_o); end
        step();
    endtask

    task automatic test_flush();
        stall = 1'b1;
        drive(1'b1, 32'h20, 32'h3333_0020);
        step();
        drive(1'b1, 32'h24, 32'h3333_0024);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h30, 32'h3333_0030);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        step();
        flush = 1'b0; stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (count_o !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got=%0d/%b exp=0/0", count_o, out_valid); end
        checks++; if (instr_o !== C_NOP || pc_o !== 32'h0 || pc4_o !== 32'h0) begin errors++; $display("FAIL flush_outs got=%h/%h/%h exp=%h/0/0", instr_o, pc_o, pc4_o, C_NOP); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_priority();
        stall = 1'b1;
        drive(1'b1, 32'h50, 32'h4444_0050);
        step();
        reset = 1'b1; flush = 1'b1;
        drive(1'b1, 32'h60, 32'h4444_0060);
        step();
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (count_o !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstprio_ctl got=%0d/%b/%b exp=0/0/1", count_o, out_valid, in_ready); end
        checks++; if (instr_o !== C_NOP || pc_o !== 32'h0 || pc4_o !== 32'h0) begin errors++; $display("FAIL rstprio_outs got=%h/%h/%h exp=%h/0/0", instr_o, pc_o, pc4_o, C_NOP); end
        // Pointers back at zero: a fresh push must appear as the head
        drive(1'b1, 32'h70, 32'h5555_0070);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (pc_o !== 32'h70 || instr_o !== 32'h5555_0070) begin errors++; $display("FAIL rstprio_fresh got=%h/%h exp=70/55550070", pc_o, instr_o); end
        step();
    endtask

    initial begin
        test_reset();
        test_push();
        test_stall_order();
        test_full_pop();
        test_push_pop_one();
        test_flush();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_register_if_id_queue
`default_nettype wire
